// File: rtl/bfly_inject_port_if.sv
// rtl/bfly_inject_port_if.sv - source handshake, channel and credit bundle for bfly_inject_port
// Optional pkt_count/stall signals exist only when BFLY_INJ_PKT_CNT_EN is defined.
interface bfly_inject_port_if #(
  parameter int CHANNEL_WIDTH = 18,
  parameter int DEST_WIDTH    = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CHANNEL_WIDTH-3:0] in_data;
  logic [DEST_WIDTH-1:0]    in_dest;
  logic                     in_last;
  logic [CHANNEL_WIDTH-1:0] out_ch;
  logic                     credit_in;
`ifdef BFLY_INJ_PKT_CNT_EN
  logic [15:0]              pkt_count;
  logic                     stall;

  modport master (
    output in_valid, in_data, in_dest, in_last, credit_in,
    input  in_ready, out_ch, pkt_count, stall
  );
  modport slave (
    input  in_valid, in_data, in_dest, in_last, credit_in,
    output in_ready, out_ch, pkt_count, stall
  );
`else
  modport master (
    output in_valid, in_data, in_dest, in_last, credit_in,
    input  in_ready, out_ch
  );
  modport slave (
    input  in_valid, in_data, in_dest, in_last, credit_in,
    output in_ready, out_ch
  );
`endif
endinterface

// File: rtl/bfly_inject_port.sv
// rtl/bfly_inject_port.sv - butterfly lane injector: payload FIFO, head/body/tail framing, credit pacing
// Optional macro BFLY_INJ_PKT_CNT_EN adds pkt_count and stall outputs.
module bfly_inject_port #(
  parameter int CHANNEL_WIDTH = 18,
  parameter int DEST_WIDTH    = 6,
  parameter int FIFO_DEPTH    = 8,
  parameter int CREDITS       = 4
) (
  input  logic              clk,
  input  logic              rst,
  bfly_inject_port_if.slave bus
);
  localparam int DW = CHANNEL_WIDTH - 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int EW = DEST_WIDTH + 1 + DW;
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE  = CW'(1);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [EW-1:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_count;
  logic [CW-1:0]            r_credits;
  logic [CHANNEL_WIDTH-1:0] r_out_ch;
  logic [CHANNEL_WIDTH-1:0] w_flit;
  logic                     w_ready;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_send;
  logic [DEST_WIDTH-1:0]    w_front_dest;
  logic                     w_front_last;
  logic [DW-1:0]            w_front_data;

  // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early
  assign w_ready = (r_count != FIFO_FULL);
  assign w_push  = bus.in_valid && w_ready;
  assign w_send  = (r_count != '0) && (r_credits != '0);
  assign {w_front_dest, w_front_last, w_front_data} = r_mem[r_rd_ptr];

  assign bus.in_ready = w_ready;
  assign bus.out_ch   = r_out_ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_send) begin
      case (r_state)
        IDLE:    w_state_nxt = BODY;
        BODY:    w_state_nxt = w_front_last ? IDLE : BODY;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // The head flit peeks at the front entry; the word itself is popped with its data flit
  always_comb begin
    w_flit = '0;
    w_pop  = 1'b0;
    if (w_send) begin
      if (r_state == IDLE) begin
        w_flit[CHANNEL_WIDTH-1 -: 2] = 2'b01;
        w_flit[DEST_WIDTH-1:0]       = w_front_dest;
      end else begin
        w_flit = {(w_front_last ? 2'b11 : 2'b10), w_front_data};
        w_pop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_dest, bus.in_last, bus.in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A returned credit while already full is dropped; send plus return cancels out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CRED_MAX;
      r_out_ch  <= '0;
    end else begin
      r_out_ch <= w_flit;
      if (w_send && !bus.credit_in) begin
        r_credits <= r_credits - CRED_ONE;
      end else if (!w_send && bus.credit_in && (r_credits != CRED_MAX)) begin
        r_credits <= r_credits + CRED_ONE;
      end
    end
  end

`ifdef BFLY_INJ_PKT_CNT_EN
  logic [15:0] r_pkt_count;
  logic        r_stall;

  assign bus.pkt_count = r_pkt_count;
  assign bus.stall     = r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_stall     <= 1'b0;
    end else begin
      if (w_flit[CHANNEL_WIDTH-1 -: 2] == 2'b11) r_pkt_count <= r_pkt_count + 16'd1;
      r_stall <= (r_count != '0) && (r_credits == '0);
    end
  end
`endif
endmodule

// File: tb/tb_bfly_inject_port.sv
// tb/tb_bfly_inject_port.sv - directed and random checks of bfly_inject_port against a queue model
// Optional pkt_count/stall checks compile in with BFLY_INJ_PKT_CNT_EN.
module tb_bfly_inject_port;
  localparam int DEPTH = 8;
  localparam int CRED  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bfly_inject_port_if #(.CHANNEL_WIDTH(18), .DEST_WIDTH(6)) bus ();

  bfly_inject_port #(
    .CHANNEL_WIDTH(18), .DEST_WIDTH(6), .FIFO_DEPTH(DEPTH), .CREDITS(CRED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [5:0]  dest;
    logic [15:0] data;
    bit          last;
    bit          first;
  } word_t;

  word_t       m_q[$];
  int          m_cred;
  bit          m_head_sent;
  bit          m_prev_last;
  logic [17:0] m_out;
  int          m_pkts;
  bit          m_stall;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          stall_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cred      = CRED;
    m_head_sent = 1'b0;
    m_prev_last = 1'b1;
    m_out       = '0;
    m_pkts      = 0;
    m_stall     = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input logic [5:0] dst,
                       input bit l, input bit c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_dest   = dst;
    bus.in_last   = l;
    bus.credit_in = c;
  endtask

  // One clock: predict from the pre-edge model, clock the DUT, compare after the edge
  task automatic tick(input string tag);
    word_t w;
    bit    ready;
    bit    send;
    ready = (m_q.size() < DEPTH);
    chk({tag, ".rdy"}, bus.in_ready, ready);
    send    = (m_q.size() > 0) && (m_cred > 0);
    m_stall = (m_q.size() > 0) && (m_cred == 0);
    m_out   = '0;
    if (send) begin
      if (m_q[0].first && !m_head_sent) begin
        m_out       = {2'b01, 10'b0, m_q[0].dest};
        m_head_sent = 1'b1;
      end else begin
        w           = m_q.pop_front();
        m_out       = {(w.last ? 2'b11 : 2'b10), w.data};
        m_head_sent = 1'b0;
        if (w.last) m_pkts = (m_pkts + 1) & 16'hFFFF;
      end
    end
    if (send && !bus.credit_in) m_cred--;
    else if (!send && bus.credit_in && m_cred < CRED) m_cred++;
    if (bus.in_valid && ready) begin
      w.dest      = bus.in_dest;
      w.data      = bus.in_data;
      w.last      = bus.in_last;
      w.first     = m_prev_last;
      m_prev_last = bus.in_last;
      m_q.push_back(w);
    end
    @(posedge clk);
    #1;
    chk({tag, ".out"}, bus.out_ch, m_out);
    chk({tag, ".cred"}, dut.r_credits, m_cred);
`ifdef BFLY_INJ_PKT_CNT_EN
    chk({tag, ".pkt"}, bus.pkt_count, m_pkts);
    chk({tag, ".stall"}, bus.stall, m_stall);
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", bus.out_ch, 18'h0);
    rst = 1'b0;
    chk("rst.rdy", bus.in_ready, 1'b1);
    chk("rst.cred", dut.r_credits, CRED);

    // single-word packet
    drive(1, 16'hBEEF, 6'h2A, 1, 0); tick("sw0");
    drive(0, '0, '0, 0, 0);          tick("sw1");
    chk("sw.head", bus.out_ch, 18'h1002A);
    tick("sw2");
    chk("sw.tail", bus.out_ch, 18'h3BEEF);
    chk("sw.cred", dut.r_credits, 2);
    tick("sw3");
    drive(0, '0, '0, 0, 1); tick("sw4"); tick("sw5");

    // three-word packet exhausts credits
    drive(1, 16'h1111, 6'h05, 0, 0); tick("tw0");
    drive(1, 16'h2222, 6'h05, 0, 0); tick("tw1");
    chk("tw.head", bus.out_ch, 18'h10005);
    drive(1, 16'h3333, 6'h05, 1, 0); tick("tw2");
    drive(0, '0, '0, 0, 0);          tick("tw3"); tick("tw4");
    chk("tw.tail", bus.out_ch, 18'h33333);
    chk("tw.cred0", dut.r_credits, 0);
    drive(1, 16'h4444, 6'h07, 1, 0); tick("cw0");
    drive(0, '0, '0, 0, 0);          tick("cw1"); tick("cw2");
    drive(0, '0, '0, 0, 1);          tick("cw3");
    drive(0, '0, '0, 0, 0);          tick("cw4");
    chk("cw.head", bus.out_ch, 18'h10007);

    // fill the FIFO behind the stalled tail
    for (int i = 0; i < 7; i++) begin
      drive(1, 16'(16'hC000 + i), 6'h09, i == 6, 0);
      tick("bp.fill");
    end
    chk("bp.full", bus.in_ready, 1'b0);
    drive(1, 16'hD00D, 6'h3F, 1, 0); tick("bp.9th");
    drive(1, 16'hD00D, 6'h3F, 1, 1); tick("bp.cr");
    drive(1, 16'hD00D, 6'h3F, 1, 0); tick("bp.pop");
    chk("bp.popflit", bus.out_ch, 18'h34444);
    chk("bp.reopen", bus.in_ready, 1'b1);
    tick("bp.acc");
    drive(0, '0, '0, 0, 1);
    for (int i = 0; i < 30; i++) tick("bp.drain");
    chk("bp.sat", dut.r_credits, CRED);

    // credit return coincident with a body send
    drive(1, 16'h5551, 6'h11, 0, 0); tick("sim0");
    drive(1, 16'h5552, 6'h11, 0, 0); tick("sim1");
    drive(1, 16'h5553, 6'h11, 1, 0); tick("sim2");
    drive(0, '0, '0, 0, 1);          tick("sim3");
    chk("sim.cred2", dut.r_credits, 2);
    drive(0, '0, '0, 0, 0);          tick("sim4");
    drive(0, '0, '0, 0, 1);          tick("sim5"); tick("sim6"); tick("sim7"); tick("sim8");
    chk("sim.sat", dut.r_credits, CRED);

    // asynchronous reset mid-packet
    drive(1, 16'hA001, 6'h15, 0, 0); tick("mr0");
    drive(1, 16'hA002, 6'h15, 0, 0); tick("mr1");
    drive(1, 16'hA003, 6'h15, 0, 0); tick("mr2");
    drive(0, '0, '0, 0, 0);
    #2 rst = 1'b1;
    #1 chk("mr.out0", bus.out_ch, 18'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mr.rdy", bus.in_ready, 1'b1);
    chk("mr.cred", dut.r_credits, CRED);
    drive(1, 16'hB0B0, 6'h21, 1, 0); tick("mr3");
    drive(0, '0, '0, 0, 0);          tick("mr4");
    chk("mr.head", bus.out_ch, 18'h10021);
    tick("mr5");

`ifdef BFLY_INJ_PKT_CNT_EN
    chk("pc.start", bus.pkt_count, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'(16'hE000 + i), 6'h02, 1, 1); tick("pc.push");
      drive(0, '0, '0, 0, 1); tick("pc.a"); tick("pc.b");
    end
    chk("pc.three", bus.pkt_count, 3);
    drive(0, '0, '0, 0, 1);
    repeat (4) tick("pc.sat");
    drive(1, 16'hF001, 6'h03, 1, 0); tick("st0");
    drive(1, 16'hF002, 6'h03, 1, 0); tick("st1");
    drive(0, '0, '0, 0, 0);          tick("st2"); tick("st3"); tick("st4");
    chk("st.cred0", dut.r_credits, 0);
    drive(1, 16'hF003, 6'h03, 1, 0); tick("st5");
    drive(0, '0, '0, 0, 0);
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick("st.hold");
      if (bus.stall) stall_cnt++;
    end
    chk("st.five", stall_cnt, 5);
    drive(0, '0, '0, 0, 1);
    repeat (6) tick("st.drain");
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 16'($urandom), 6'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) < 2);
      tick("rnd");
    end
    drive(0, '0, '0, 0, 1);
    for (int i = 0; i < 40; i++) tick("rnd.drain");
    chk("rnd.empty", dut.r_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
